// File: rtl/snoop_bus_arbiter_if.sv
// Bus bundle between the snoop arbiter, the per-CPU cache controllers and main memory.
// The arbiter uses the master modport; caches and memory use the slave modport.
interface snoop_bus_arbiter_if #(
    parameter int unsigned N_REQ  = 2,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 4
);
    localparam int unsigned SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]        req;
    logic [2*N_REQ-1:0]      op;
    logic [ADDR_W*N_REQ-1:0] addr;
    logic [DATA_W*N_REQ-1:0] wdata;
    logic [N_REQ-1:0]        grant;
    logic [N_REQ-1:0]        done;
    logic [DATA_W-1:0]       rdata;
    logic                    bus_valid;
    logic [1:0]              bus_op;
    logic [ADDR_W-1:0]       bus_addr;
    logic [SRC_W-1:0]        bus_src;
    logic [N_REQ-1:0]        snoop_dirty;
    logic [DATA_W*N_REQ-1:0] snoop_data;
    logic                    mem_rd;
    logic                    mem_wr;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic [DATA_W-1:0]       mem_rdata;
    logic                    busy;

    modport master (
        input  req, op, addr, wdata, snoop_dirty, snoop_data, mem_rdata,
        output grant, done, rdata, bus_valid, bus_op, bus_addr, bus_src,
               mem_rd, mem_wr, mem_addr, mem_wdata, busy
    );

    modport slave (
        output req, op, addr, wdata, snoop_dirty, snoop_data, mem_rdata,
        input  grant, done, rdata, bus_valid, bus_op, bus_addr, bus_src,
               mem_rd, mem_wr, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/snoop_bus_arbiter.sv
// Round-robin arbiter and sequencer for a shared snooping bus: grant, broadcast,
// then take the block from a dirty snooper (flushing it to memory) or from memory.
module snoop_bus_arbiter #(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic                clock,
    input  logic                resetn,
    snoop_bus_arbiter_if.master bus
);
    localparam int unsigned SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;

    localparam logic [1:0] OP_INVAL = 2'b10;
    localparam logic [1:0] OP_WBACK = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_BCAST, S_MEM, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [SRC_W-1:0]    rr_q, rr_d;
    logic [SRC_W-1:0]    src_q, src_d;
    logic [1:0]          op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [N_REQ-1:0]    done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                bus_valid_q, bus_valid_d;
    logic                mem_rd_q, mem_rd_d;
    logic                mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                busy_q, busy_d;

    logic                win_found;
    logic [SRC_W-1:0]    win_idx;
    logic [SRC_W-1:0]    cand;
    logic [N_REQ-1:0]    dirty_masked;
    logic                dirty_found;
    logic [DATA_W-1:0]   dirty_data;

    // Round-robin winner: first asserted request scanning upward from the pointer
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = SRC_W'((32'(rr_q) + 32'(i)) % N_REQ);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Lowest-index dirty snooper, ignoring the bus owner's own line
    always_comb begin
        dirty_masked = bus.snoop_dirty & ~grant_q;
        dirty_found  = 1'b0;
        dirty_data   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!dirty_found && dirty_masked[i]) begin
                dirty_found = 1'b1;
                dirty_data  = bus.snoop_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        src_d       = src_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        done_d      = '0;
        rdata_d     = rdata_q;
        bus_valid_d = 1'b0;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d     = S_BCAST;
                    src_d       = win_idx;
                    op_d        = bus.op[32'(win_idx)*2 +: 2];
                    addr_d      = bus.addr[32'(win_idx)*ADDR_W +: ADDR_W];
                    wdata_d     = bus.wdata[32'(win_idx)*DATA_W +: DATA_W];
                    grant_d     = N_REQ'(1) << win_idx;
                    bus_valid_d = 1'b1;
                end
            end
            S_BCAST: begin
                if (op_q == OP_INVAL) begin
                    state_d = S_DONE;
                    done_d  = grant_q;
                end else if (op_q == OP_WBACK) begin
                    state_d     = S_MEM;
                    cnt_d       = CNT_W'(MEM_LAT - 1);
                    mem_wr_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = wdata_q;
                end else if (dirty_found) begin
                    // Cache-to-cache fill; the dirty copy is flushed to memory alongside done
                    state_d     = S_DONE;
                    done_d      = grant_q;
                    rdata_d     = dirty_data;
                    mem_wr_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = dirty_data;
                end else begin
                    state_d    = S_MEM;
                    cnt_d      = CNT_W'(MEM_LAT - 1);
                    mem_rd_d   = 1'b1;
                    mem_addr_d = addr_q;
                end
            end
            S_MEM: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    done_d  = grant_q;
                    if (!op_q[1]) begin
                        rdata_d = bus.mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                grant_d = '0;
                rr_d    = (src_q == SRC_W'(N_REQ - 1)) ? '0 : src_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            src_q       <= '0;
            op_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            rdata_q     <= '0;
            bus_valid_q <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            src_q       <= src_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            bus_valid_q <= bus_valid_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.done      = done_q;
    assign bus.rdata     = rdata_q;
    assign bus.bus_valid = bus_valid_q;
    assign bus.bus_op    = op_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_src   = src_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter: arbitration order, snoop flush, memory paths, reset.
module tb_snoop_bus_arbiter;
    logic clock;
    logic resetn;
    int   n_cmp;
    int   n_err;

    snoop_bus_arbiter_if #(.N_REQ(2), .ADDR_W(3), .DATA_W(4)) bus_if ();

    snoop_bus_arbiter #(.N_REQ(2), .ADDR_W(3), .DATA_W(4), .MEM_LAT(2)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled on the falling edge
    task automatic step();
        @(posedge clock);
        @(negedge clock);
        chk("grant_onehot", 32'($onehot0(bus_if.grant)), 32'd1);
        chk("done_onehot", 32'($onehot0(bus_if.done)), 32'd1);
    endtask

    // Called in cycle 0; returns in the done cycle with the requester's req dropped
    task automatic wait_done(input int who, input int exp_cyc);
        int  n    = 0;
        bit  seen = 1'b0;
        while (!seen && n < 12) begin
            step();
            n++;
            if (bus_if.done != '0) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("done_vec", 32'(bus_if.done), 32'd1 << who);
        chk("done_grant", 32'(bus_if.grant), 32'd1 << who);
        chk("done_latency", 32'(n), 32'(exp_cyc));
        bus_if.req[who] = 1'b0;
    endtask

    task automatic set_req(input int who, input logic [1:0] op, input logic [2:0] a,
                           input logic [3:0] wd);
        bus_if.op[who*2 +: 2]    = op;
        bus_if.addr[who*3 +: 3]  = a;
        bus_if.wdata[who*4 +: 4] = wd;
        bus_if.req[who]          = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        resetn             = 1'b0;
        bus_if.req         = '0;
        bus_if.op          = '0;
        bus_if.addr        = '0;
        bus_if.wdata       = '0;
        bus_if.snoop_dirty = '0;
        bus_if.snoop_data  = '0;
        bus_if.mem_rdata   = '0;
        @(negedge clock);
        repeat (3) step();

        chk("rst_grant", 32'(bus_if.grant), 32'd0);
        chk("rst_done", 32'(bus_if.done), 32'd0);
        chk("rst_busy", 32'(bus_if.busy), 32'd0);
        chk("rst_bus_valid", 32'(bus_if.bus_valid), 32'd0);
        chk("rst_mem_strobes", 32'({bus_if.mem_rd, bus_if.mem_wr}), 32'd0);
        chk("rst_rdata", 32'(bus_if.rdata), 32'd0);
        resetn = 1'b1;
        step();

        // Both request with rr=0: requester 0 first, then 1
        set_req(0, 2'b10, 3'd1, 4'h0);
        set_req(1, 2'b10, 3'd6, 4'h0);
        wait_done(0, 2);
        step();
        chk("t2_idle_grant", 32'(bus_if.grant), 32'd0);
        chk("t2_idle_busy", 32'(bus_if.busy), 32'd0);
        wait_done(1, 2);
        step();

        // Clean RDMISS by req0 at addr 5
        bus_if.mem_rdata = 4'hA;
        set_req(0, 2'b00, 3'd5, 4'h0);
        step();
        chk("t1_bus_valid", 32'(bus_if.bus_valid), 32'd1);
        chk("t1_bus_op", 32'(bus_if.bus_op), 32'd0);
        chk("t1_bus_addr", 32'(bus_if.bus_addr), 32'd5);
        chk("t1_bus_src", 32'(bus_if.bus_src), 32'd0);
        chk("t1_grant", 32'(bus_if.grant), 32'd1);
        chk("t1_busy", 32'(bus_if.busy), 32'd1);
        chk("t1_mem_rd_c1", 32'(bus_if.mem_rd), 32'd0);
        step();
        chk("t1_mem_rd_c2", 32'(bus_if.mem_rd), 32'd1);
        chk("t1_mem_addr_c2", 32'(bus_if.mem_addr), 32'd5);
        chk("t1_bus_valid_c2", 32'(bus_if.bus_valid), 32'd0);
        step();
        chk("t1_mem_rd_c3", 32'(bus_if.mem_rd), 32'd0);
        chk("t1_mem_addr_c3", 32'(bus_if.mem_addr), 32'd5);
        chk("t1_done_c3", 32'(bus_if.done), 32'd0);
        step();
        chk("t1_done_c4", 32'(bus_if.done), 32'd1);
        chk("t1_rdata", 32'(bus_if.rdata), 32'hA);
        bus_if.req[0] = 1'b0;
        step();
        chk("t1_idle_grant", 32'(bus_if.grant), 32'd0);
        chk("t1_idle_busy", 32'(bus_if.busy), 32'd0);

        // rr=1 now: both request, requester 1 first, then 0
        set_req(0, 2'b10, 3'd2, 4'h0);
        set_req(1, 2'b10, 3'd3, 4'h0);
        wait_done(1, 2);
        step();
        wait_done(0, 2);
        step();

        // WRMISS by req1 with snooper 0 dirty: flush path
        bus_if.snoop_dirty = 2'b01;
        bus_if.snoop_data  = 8'hF7;
        set_req(1, 2'b01, 3'd2, 4'h0);
        step();
        chk("t3_mem_rd_c1", 32'(bus_if.mem_rd), 32'd0);
        step();
        chk("t3_done", 32'(bus_if.done), 32'd2);
        chk("t3_rdata", 32'(bus_if.rdata), 32'h7);
        chk("t3_mem_wr", 32'(bus_if.mem_wr), 32'd1);
        chk("t3_mem_addr", 32'(bus_if.mem_addr), 32'd2);
        chk("t3_mem_wdata", 32'(bus_if.mem_wdata), 32'h7);
        chk("t3_mem_rd_c2", 32'(bus_if.mem_rd), 32'd0);
        bus_if.req[1] = 1'b0;
        step();
        chk("t3_mem_wr_after", 32'(bus_if.mem_wr), 32'd0);

        // INVAL by req0 with only its own dirty bit set
        bus_if.snoop_data = 8'h0F;
        set_req(0, 2'b10, 3'd4, 4'h0);
        wait_done(0, 2);
        chk("t4_mem_strobes", 32'({bus_if.mem_rd, bus_if.mem_wr}), 32'd0);
        step();

        // RDMISS by req0 with only its own dirty bit: must go to memory
        bus_if.mem_rdata = 4'h3;
        set_req(0, 2'b00, 3'd7, 4'h0);
        wait_done(0, 4);
        chk("t4b_rdata", 32'(bus_if.rdata), 32'h3);
        step();
        bus_if.snoop_dirty = '0;

        // WBACK by req1 to addr 3
        set_req(1, 2'b11, 3'd3, 4'hC);
        step();
        chk("t5_bus_op", 32'(bus_if.bus_op), 32'd3);
        step();
        chk("t5_mem_wr", 32'(bus_if.mem_wr), 32'd1);
        chk("t5_mem_addr", 32'(bus_if.mem_addr), 32'd3);
        chk("t5_mem_wdata", 32'(bus_if.mem_wdata), 32'hC);
        chk("t5_mem_rd", 32'(bus_if.mem_rd), 32'd0);
        step();
        chk("t5_mem_wr_c3", 32'(bus_if.mem_wr), 32'd0);
        chk("t5_mem_addr_c3", 32'(bus_if.mem_addr), 32'd3);
        step();
        chk("t5_done", 32'(bus_if.done), 32'd2);
        bus_if.req[1] = 1'b0;
        step();

        // Move rr to 1, then reset in the middle of a WBACK
        set_req(0, 2'b10, 3'd0, 4'h0);
        wait_done(0, 2);
        step();
        set_req(1, 2'b11, 3'd1, 4'h5);
        step();
        step();
        chk("t6_busy_in_mem", 32'(bus_if.busy), 32'd1);
        resetn = 1'b0;
        step();
        chk("t6_grant", 32'(bus_if.grant), 32'd0);
        chk("t6_busy", 32'(bus_if.busy), 32'd0);
        chk("t6_done", 32'(bus_if.done), 32'd0);
        chk("t6_mem_strobes", 32'({bus_if.mem_rd, bus_if.mem_wr}), 32'd0);
        chk("t6_bus_valid", 32'(bus_if.bus_valid), 32'd0);
        resetn = 1'b1;
        set_req(0, 2'b10, 3'd2, 4'h0);
        set_req(1, 2'b10, 3'd2, 4'h0);
        wait_done(0, 2);
        step();
        wait_done(1, 2);
        step();
        chk("end_busy", 32'(bus_if.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
